// File: rtl/toggle_arb_pkg.sv
// Shared types and constants for the toggle-element arbiter.
package toggle_arb_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_ERR
    } state_t;

    // Cycles the toggle element is held in reset after arbiter reset.
    localparam int unsigned INIT_CYCLES = 2;

    // Toggle output side encoding; also the encoding of steer.
    localparam logic DOT   = 1'b0;
    localparam logic BLANK = 1'b1;

endpackage

// File: rtl/toggle_arb_rr.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] idx_c
);

    localparam int unsigned PW = $clog2(N);

    logic found;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned j;
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                grant_c[j] = 1'b1;
                idx_c      = PW'(j);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_arb.sv
// Arbitrates N_REQ requesters onto one asynchronous toggle element and
// checks that each event returns on the expected alternating output.
module toggle_arb
    import toggle_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             done,
    output logic             steer,
    output logic             busy,
    output logic             err,
    output logic             tog_in,
    output logic             tog_rstn,
    input  logic             tog_dot,
    input  logic             tog_blank
);

    localparam int unsigned PW  = $clog2(N_REQ);
    localparam int unsigned CW  = 8;
    localparam int unsigned ICW = $clog2(INIT_CYCLES + 1);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic             exp_side;
    logic [CW-1:0]    tcnt;
    logic [ICW-1:0]   icnt;

    logic             dot_s1, dot_s2, dot_s3;
    logic             blank_s1, blank_s2, blank_s3;

    logic [N_REQ-1:0] pick_c;
    logic [PW-1:0]    pick_idx_c;
    logic             dot_edge_c, blank_edge_c, any_edge_c;
    logic             exp_edge_c, other_edge_c;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant_c (pick_c),
        .idx_c   (pick_idx_c)
    );

    // Edges on the synchronized toggle outputs, split by expected side.
    always_comb begin
        dot_edge_c   = dot_s2 ^ dot_s3;
        blank_edge_c = blank_s2 ^ blank_s3;
        any_edge_c   = dot_edge_c | blank_edge_c;
        exp_edge_c   = (exp_side == DOT) ? dot_edge_c : blank_edge_c;
        other_edge_c = (exp_side == DOT) ? blank_edge_c : dot_edge_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            ptr      <= '0;
            exp_side <= DOT;
            tcnt     <= '0;
            icnt     <= '0;
            grant    <= '0;
            done     <= 1'b0;
            steer    <= DOT;
            busy     <= 1'b0;
            err      <= 1'b0;
            tog_in   <= 1'b0;
            tog_rstn <= 1'b0;
            dot_s1   <= 1'b0;
            dot_s2   <= 1'b0;
            dot_s3   <= 1'b0;
            blank_s1 <= 1'b0;
            blank_s2 <= 1'b0;
            blank_s3 <= 1'b0;
        end else begin
            dot_s1   <= tog_dot;
            dot_s2   <= dot_s1;
            dot_s3   <= dot_s2;
            blank_s1 <= tog_blank;
            blank_s2 <= blank_s1;
            blank_s3 <= blank_s2;
            done     <= 1'b0;

            case (state)
                S_INIT: begin
                    if (icnt == ICW'(INIT_CYCLES - 1)) begin
                        tog_rstn <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        icnt <= icnt + ICW'(1);
                    end
                end

                S_IDLE: begin
                    // The element must stay quiet when no event is outstanding.
                    if (any_edge_c) begin
                        err   <= 1'b1;
                        state <= S_ERR;
                    end else if (|req) begin
                        grant <= pick_c;
                        busy  <= 1'b1;
                        ptr   <= (pick_idx_c == PW'(N_REQ - 1)) ? '0
                                                                : pick_idx_c + PW'(1);
                        state <= S_FIRE;
                    end
                end

                S_FIRE: begin
                    if (any_edge_c) begin
                        err   <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        tog_in <= ~tog_in;
                        tcnt   <= '0;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if ((dot_edge_c && blank_edge_c) || other_edge_c) begin
                        err   <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else if (exp_edge_c) begin
                        done     <= 1'b1;
                        steer    <= exp_side;
                        grant    <= '0;
                        busy     <= 1'b0;
                        exp_side <= ~exp_side;
                        state    <= S_IDLE;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end

                S_ERR: begin
                    err   <= 1'b1;
                    grant <= '0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_arb.sv
// Scoreboard bench for toggle_arb with a behavioural toggle-element model.
module tb_toggle_arb;

    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_WRONG  = 2;

    typedef struct {
        logic [3:0] g;
        logic       s;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       done, steer, busy, err, tog_in, tog_rstn;
    logic       tog_dot = 1'b0;
    logic       tog_blank = 1'b0;

    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   mode = M_NORMAL;
    int   dly = 0;
    exp_t sb_q[$];
    logic [3:0] last_grant = '0;

    toggle_arb #(.N_REQ(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .done      (done),
        .steer     (steer),
        .busy      (busy),
        .err       (err),
        .tog_in    (tog_in),
        .tog_rstn  (tog_rstn),
        .tog_dot   (tog_dot),
        .tog_blank (tog_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Toggle element: dot first after reset, then alternating; optional
    // silent or wrong-side behaviour and a response delay in clock cycles.
    initial begin : model
        logic phase;
        logic last_in;
        phase   = 1'b0;
        last_in = 1'b0;
        forever begin
            @(tog_in or tog_rstn);
            #1;
            if (tog_rstn !== 1'b1) begin
                tog_dot   = 1'b0;
                tog_blank = 1'b0;
                phase     = 1'b0;
                last_in   = 1'b0;
            end else if (tog_in !== last_in) begin
                logic aborted;
                int   k;
                last_in = tog_in;
                aborted = 1'b0;
                k       = 0;
                while (k < dly && !aborted) begin
                    @(posedge clk);
                    if (tog_rstn !== 1'b1) aborted = 1'b1;
                    k++;
                end
                #1;
                if (aborted || tog_rstn !== 1'b1) begin
                    tog_dot   = 1'b0;
                    tog_blank = 1'b0;
                    phase     = 1'b0;
                    last_in   = 1'b0;
                end else if (mode != M_SILENT) begin
                    if ((mode == M_WRONG) ? ~phase : phase) tog_blank = ~tog_blank;
                    else                                     tog_dot   = ~tog_dot;
                    phase = ~phase;
                end
            end
        end
    end

    // Monitor: every done pops one expected (grant, steer) pair.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_grant", 32'(last_grant), 32'(e.g));
                chk("done_steer", 32'(steer), 32'(e.s));
            end
        end
        if (grant !== 4'b0000) last_grant = grant;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input logic s);
        exp_t e;
        e.g = g;
        e.s = s;
        sb_q.push_back(e);
    endtask

    task automatic wait_dones(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_tog_in(input string name);
        int k;
        k = 0;
        while (tog_in !== 1'b1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, 32'(tog_in), 32'd1);
    endtask

    initial begin : stim
        int base, t, low;
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tog_in", 32'(tog_in), 32'd0);
        chk("init_tog_rstn", 32'(tog_rstn), 32'd1);

        // Single request, immediate dot answer: minimum latency.
        mode = M_NORMAL;
        dly  = 0;
        base = done_cnt;
        push(4'b0001, 1'b0);
        req = 4'b0001;
        t = 0;
        while (grant === 4'b0000 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("first_grant", 32'(grant), 32'b0001);
        chk("first_busy", 32'(busy), 32'd1);
        t = 0;
        while (done_cnt < base + 1 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        req = '0;
        chk("min_latency", 32'(t), 32'd4);
        chk("tog_in_after_done", 32'(tog_in), 32'd1);
        chk("grant_after_done", 32'(grant), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);

        // All requesters held: rotation and alternating sides.
        do_reset();
        dly  = 2;
        base = done_cnt;
        push(4'b0001, 1'b0);
        push(4'b0010, 1'b1);
        push(4'b0100, 1'b0);
        push(4'b1000, 1'b1);
        req = 4'b1111;
        wait_dones("rr_four_done", base + 4, 120);
        req = '0;
        @(negedge clk);
        #1;
        chk("rr_idle_grant", 32'(grant), 32'd0);

        // Silent element: timeout measured from WAIT entry.
        do_reset();
        mode = M_SILENT;
        base = done_cnt;
        req  = 4'b0001;
        wait_tog_in("to_fire");
        t = 0;
        while (err !== 1'b1 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        req = '0;
        chk("timeout_cycles", 32'(t), 32'd15);
        chk("timeout_grant", 32'(grant), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_tog_in_frozen", 32'(tog_in), 32'd1);
        chk("timeout_no_done", 32'(done_cnt), 32'(base));

        // Element answers on blank for the first event.
        do_reset();
        chk("err_cleared_by_rst", 32'(err), 32'd0);
        mode = M_WRONG;
        dly  = 1;
        base = done_cnt;
        req  = 4'b0001;
        t = 0;
        while (err !== 1'b1 && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        req = '0;
        chk("wrong_side_err", 32'(err), 32'd1);
        chk("wrong_side_grant", 32'(grant), 32'd0);
        chk("wrong_side_no_done", 32'(done_cnt), 32'(base));

        // Reset in the middle of WAIT abandons the transaction.
        do_reset();
        mode = M_NORMAL;
        dly  = 8;
        base = done_cnt;
        req  = 4'b0001;
        wait_tog_in("mid_wait_fire");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_steer", 32'(steer), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_tog_in", 32'(tog_in), 32'd0);
        chk("midrst_tog_rstn", 32'(tog_rstn), 32'd0);
        low = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (tog_rstn === 1'b0) low++;
        end
        chk("tog_rstn_low_cycles", 32'(low), 32'd2);
        chk("midrst_no_done", 32'(done_cnt), 32'(base));
        dly = 0;
        push(4'b0001, 1'b0);
        req = 4'b0001;
        wait_dones("post_rst_done", base + 1, 20);
        req = '0;

        // Request dropped while waiting: transaction still completes once.
        do_reset();
        dly  = 3;
        base = done_cnt;
        push(4'b0100, 1'b0);
        req = 4'b0100;
        wait_tog_in("drop_fire");
        req = '0;
        wait_dones("drop_done", base + 1, 20);
        @(negedge clk);
        #1;
        chk("drop_grant", 32'(grant), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        chk("drop_single_done", 32'(done_cnt), 32'(base + 1));

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
